// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    // Transmit FSM states; the encoding is visible on the debug port.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // 100 MHz system clock, 115200 baud.
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    // Even parity makes the total count of ones even; odd makes it odd.
    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        return (mode == PARITY_EVEN) ? ^data : ~^data;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_end
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] TERMINAL = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    assign bit_end = (count == TERMINAL);

    // Restart on every bit boundary so the counter never wraps on its own.
    always_ff @(posedge clk) begin
        if (reset || clear || bit_end) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter with a one-byte holding register for back-to-back frames.
//
// Handshake: tx_DV is a one-cycle strobe with no ready/back-pressure. Every
// high cycle is one offer of tx_byte. Offers are never stalled: a busy
// transmitter parks one byte in the hold register and drops any further
// byte while hold is full, flagging the drop with tx_overrun.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int PARITY       = PARITY_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_byte,
    input  logic       tx_DV,
    output logic       tx_serial,
    output logic       tx_active,
    output logic       uart_done,
    output logic       tx_overrun,
    output state_t     fsm_state
);

    localparam logic HAS_PARITY = (PARITY != PARITY_NONE);
    localparam logic STOP_LAST  = (STOP_BITS == 2);

    state_t     state;
    state_t     next_state;
    logic       bit_end;
    logic       frame_end;
    logic [7:0] tx_data;
    logic [7:0] hold_byte;
    logic       hold_valid;
    logic [2:0] bit_idx;
    logic       stop_idx;

    assign fsm_state = state;
    assign frame_end = (state == ST_STOP) && bit_end && (stop_idx == STOP_LAST);

    // Counter is held at zero while idle so a new frame starts on a clean bit.
    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .reset   (reset),
        .clear   (state == ST_IDLE),
        .bit_end (bit_end)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and line outputs, decoded from registered state only.
    always_comb begin
        next_state = state;
        tx_serial  = 1'b1;
        tx_active  = 1'b1;
        case (state)
            ST_IDLE: begin
                tx_active = 1'b0;
                if (tx_DV) next_state = ST_START;
            end
            ST_START: begin
                tx_serial = 1'b0;
                if (bit_end) next_state = ST_DATA;
            end
            ST_DATA: begin
                tx_serial = tx_data[bit_idx];
                if (bit_end && (bit_idx == 3'd7)) next_state = HAS_PARITY ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                tx_serial = parity_bit(tx_data, PARITY);
                if (bit_end) next_state = ST_STOP;
            end
            ST_STOP: begin
                // A held byte or a same-cycle strobe chains straight into START.
                if (frame_end) next_state = (hold_valid || tx_DV) ? ST_START : ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
                tx_active  = 1'b0;
            end
        endcase
    end

    // Datapath: frame byte, hold buffer, bit/stop indices and status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_data    <= '0;
            hold_byte  <= '0;
            hold_valid <= 1'b0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            uart_done  <= 1'b0;
            tx_overrun <= 1'b0;
        end else begin
            uart_done  <= frame_end;
            tx_overrun <= 1'b0;
            if (state == ST_IDLE) begin
                bit_idx  <= '0;
                stop_idx <= 1'b0;
                if (tx_DV) tx_data <= tx_byte;
            end else if (frame_end) begin
                bit_idx  <= '0;
                stop_idx <= 1'b0;
                if (hold_valid) begin
                    // Held byte goes out next; a same-cycle strobe refills hold.
                    tx_data <= hold_byte;
                    if (tx_DV) begin
                        hold_byte <= tx_byte;
                    end else begin
                        hold_valid <= 1'b0;
                    end
                end else if (tx_DV) begin
                    tx_data <= tx_byte;
                end
            end else begin
                if (tx_DV) begin
                    if (hold_valid) begin
                        tx_overrun <= 1'b1;
                    end else begin
                        hold_byte  <= tx_byte;
                        hold_valid <= 1'b1;
                    end
                end
                if ((state == ST_DATA) && bit_end) begin
                    bit_idx <= (bit_idx == 3'd7) ? 3'd0 : bit_idx + 3'd1;
                end
                if ((state == ST_STOP) && bit_end) begin
                    stop_idx <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: an 8N1 instance and an 8E2 instance, each
// watched by a mid-bit sampling RX model feeding a byte scoreboard.
module tb_uart_tx_serializer;
    import uart_pkg::*;

    localparam int CPB = 4;
    localparam logic [255:0] RESPONSE =
        256'hDEADBEEF_0BADF00D_CAFEBABE_12345678_9ABCDEF0_FEEDFACE_A5A55A5A_0F1E2D3C;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs ----------------
    logic [7:0] byte_a = '0;
    logic [7:0] byte_b = '0;
    logic       dv_a   = 1'b0;
    logic       dv_b   = 1'b0;
    logic       ser_a, act_a, done_a, ovr_a;
    logic       ser_b, act_b, done_b, ovr_b;
    state_t     st_a, st_b;

    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY(PARITY_NONE), .STOP_BITS(1)) dut_a (
        .clk(clk), .reset(reset), .tx_byte(byte_a), .tx_DV(dv_a),
        .tx_serial(ser_a), .tx_active(act_a), .uart_done(done_a),
        .tx_overrun(ovr_a), .fsm_state(st_a)
    );

    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY(PARITY_EVEN), .STOP_BITS(2)) dut_b (
        .clk(clk), .reset(reset), .tx_byte(byte_b), .tx_DV(dv_b),
        .tx_serial(ser_b), .tx_active(act_b), .uart_done(done_b),
        .tx_overrun(ovr_b), .fsm_state(st_b)
    );

    // ---------------- scoreboard state ----------------
    int         n_checks = 0;
    int         n_fail   = 0;
    logic       rx_en_a  = 1'b1;
    logic [7:0] exp_q_a[$];
    logic [7:0] exp_q_b[$];
    int         rx_start_a[$];
    int         done_cnt_a = 0;
    int         done_cnt_b = 0;
    int         ovr_cnt_a  = 0;
    int         ovr_cyc_a  = 0;
    int         act_cnt_a  = 0;
    int         act_cnt_b  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic line_of(input int which);
        return (which == 0) ? ser_a : ser_b;
    endfunction

    function automatic logic done_of(input int which);
        return (which == 0) ? done_a : done_b;
    endfunction

    // RX model: entered on the first start-bit cycle, samples each bit at
    // its middle, returns on the last stop-bit cycle.
    task automatic rx_frame(input int which, input int par, input int stops,
                            output logic [7:0] d, output logic ok, output int sc);
        logic p;
        ok = 1'b1;
        sc = cyc;
        d  = '0;
        repeat (CPB / 2) @(negedge clk);
        if (line_of(which) !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            d[i] = line_of(which);
        end
        if (par != PARITY_NONE) begin
            repeat (CPB) @(negedge clk);
            p = (par == PARITY_EVEN) ? ^d : ~^d;
            if (line_of(which) !== p) ok = 1'b0;
        end
        for (int s = 0; s < stops; s++) begin
            repeat (CPB) @(negedge clk);
            if (line_of(which) !== 1'b1) ok = 1'b0;
        end
        repeat (CPB - CPB / 2 - 1) @(negedge clk);
    endtask

    // ---------------- monitors ----------------
    always begin : rx_monitor_a
        logic [7:0] d;
        logic       ok;
        int         sc;
        @(negedge clk);
        if (rx_en_a && !reset && ser_a === 1'b0) begin
            rx_frame(0, PARITY_NONE, 1, d, ok, sc);
            rx_start_a.push_back(sc);
            check("rx_a_framing", ok, 1);
            check("rx_a_frame_expected", exp_q_a.size() != 0, 1);
            if (exp_q_a.size() != 0) check("rx_a_byte", d, exp_q_a.pop_front());
        end
    end

    always begin : rx_monitor_b
        logic [7:0] d;
        logic       ok;
        int         sc;
        @(negedge clk);
        if (!reset && ser_b === 1'b0) begin
            rx_frame(1, PARITY_EVEN, 2, d, ok, sc);
            check("rx_b_framing", ok, 1);
            check("rx_b_frame_expected", exp_q_b.size() != 0, 1);
            if (exp_q_b.size() != 0) check("rx_b_byte", d, exp_q_b.pop_front());
        end
    end

    always @(negedge clk) begin
        if (done_a === 1'b1) done_cnt_a <= done_cnt_a + 1;
        if (done_b === 1'b1) done_cnt_b <= done_cnt_b + 1;
        if (act_a === 1'b1)  act_cnt_a  <= act_cnt_a + 1;
        if (act_b === 1'b1)  act_cnt_b  <= act_cnt_b + 1;
        if (ovr_a === 1'b1) begin
            ovr_cnt_a <= ovr_cnt_a + 1;
            ovr_cyc_a <= cyc;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic strobe_a(input logic [7:0] b, output int sc);
        @(posedge clk); #1;
        byte_a = b;
        dv_a   = 1'b1;
        sc     = cyc;
        @(posedge clk); #1;
        dv_a   = 1'b0;
    endtask

    task automatic strobe_b(input logic [7:0] b, output int sc);
        @(posedge clk); #1;
        byte_b = b;
        dv_b   = 1'b1;
        sc     = cyc;
        @(posedge clk); #1;
        dv_b   = 1'b0;
    endtask

    // Returns the cycle of the next uart_done pulse, or -1 when the budget runs out.
    task automatic wait_done(input int which, input int budget, output int dc);
        dc = -1;
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            if (done_of(which) === 1'b1) begin
                dc = cyc;
                break;
            end
        end
    endtask

    // Stand-in for uart_controller: challenge byte, then the response MSB-byte first,
    // each byte released by the previous frame's uart_done.
    task automatic controller_run(input logic [255:0] resp, output logic ctrl_done);
        int         s;
        int         dc;
        logic [7:0] b;
        ctrl_done = 1'b0;
        exp_q_a.push_back(8'h11);
        strobe_a(8'h11, s);
        for (int i = 0; i < 32; i++) begin
            b = resp[255 - 8 * i -: 8];
            exp_q_a.push_back(b);
            wait_done(0, 100, dc);
            if (dc < 0) return;
            strobe_a(b, s);
        end
        wait_done(0, 100, dc);
        ctrl_done = (dc >= 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int         s, s2, s3, dc, dc2, d0, a0, o0;
        logic [9:0] pat;
        logic [3:0] samp;
        logic       ctrl_done;

        // Reset state of both instances.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_a_serial", ser_a, 1);
        check("rst_a_active", act_a, 0);
        check("rst_a_done", done_a, 0);
        check("rst_a_overrun", ovr_a, 0);
        check("rst_a_state", st_a, ST_IDLE);
        check("rst_b_serial", ser_b, 1);
        check("rst_b_active", act_b, 0);
        check("rst_b_state", st_b, ST_IDLE);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // Single byte 0xA5, 8N1: start, LSB-first data, stop, 4 cycles each.
        pat = 10'b11_0100_1010;
        d0  = done_cnt_a;
        a0  = act_cnt_a;
        exp_q_a.push_back(8'hA5);
        strobe_a(8'hA5, s);
        for (int j = 0; j < 10; j++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                samp[c] = ser_a;
            end
            check("t1_line_bit", samp, {4{pat[j]}});
        end
        wait_done(0, 20, dc);
        check("t1_done_latency", dc - s, 41);
        repeat (3) @(negedge clk);
        check("t1_done_count", done_cnt_a - d0, 1);
        check("t1_active_cycles", act_cnt_a - a0, 40);

        // 0x3C then 0xC3 five cycles later: second frame follows with no gap.
        repeat (4) @(posedge clk);
        d0 = done_cnt_a;
        a0 = act_cnt_a;
        o0 = ovr_cnt_a;
        exp_q_a.push_back(8'h3C);
        exp_q_a.push_back(8'hC3);
        strobe_a(8'h3C, s);
        repeat (3) @(posedge clk);
        strobe_a(8'hC3, s2);
        check("t2_strobe_spacing", s2 - s, 5);
        wait_done(0, 60, dc);
        wait_done(0, 60, dc2);
        check("t2_first_done", dc - s, 41);
        check("t2_done_spacing", dc2 - dc, 40);
        repeat (3) @(negedge clk);
        check("t2_done_count", done_cnt_a - d0, 2);
        check("t2_active_cycles", act_cnt_a - a0, 80);
        check("t2_no_overrun", ovr_cnt_a - o0, 0);
        check("t2_rx_frames", rx_start_a.size() >= 2, 1);
        if (rx_start_a.size() >= 2) check("t2_contiguous", rx_start_a[$] - rx_start_a[$-1], 40);

        // Three strobes inside one frame: third is dropped.
        repeat (4) @(posedge clk);
        d0 = done_cnt_a;
        o0 = ovr_cnt_a;
        exp_q_a.push_back(8'h01);
        exp_q_a.push_back(8'h02);
        strobe_a(8'h01, s);
        strobe_a(8'h02, s2);
        strobe_a(8'h03, s3);
        wait_done(0, 60, dc);
        wait_done(0, 60, dc2);
        check("t3_first_done", dc - s, 41);
        check("t3_hold_back_to_back", dc2 - dc, 40);
        repeat (60) @(negedge clk);
        check("t3_done_count", done_cnt_a - d0, 2);
        check("t3_overrun_count", ovr_cnt_a - o0, 1);
        check("t3_overrun_cycle", ovr_cyc_a - s3, 1);
        check("t3_queue_drained", exp_q_a.size(), 0);

        // 8E2 instance, byte 0x07: parity 1, two stop bits, 48-cycle frame.
        d0 = done_cnt_b;
        a0 = act_cnt_b;
        exp_q_b.push_back(8'h07);
        strobe_b(8'h07, s);
        repeat (35) @(negedge clk);
        check("t4_data_bit7", ser_b, 0);
        repeat (4) @(negedge clk);
        check("t4_parity_bit", ser_b, 1);
        repeat (8) @(negedge clk);
        check("t4_second_stop_line", ser_b, 1);
        check("t4_second_stop_active", act_b, 1);
        wait_done(1, 20, dc);
        check("t4_done_latency", dc - s, 49);
        repeat (3) @(negedge clk);
        check("t4_done_count", done_cnt_b - d0, 1);
        check("t4_active_cycles", act_cnt_b - a0, 48);

        // Reset during the third data bit of 0xFF.
        rx_en_a = 1'b0;
        d0 = done_cnt_a;
        strobe_a(8'hFF, s);
        repeat (13) @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("t5_serial_after_reset", ser_a, 1);
        check("t5_active_after_reset", act_a, 0);
        check("t5_state_after_reset", st_a, ST_IDLE);
        repeat (60) @(negedge clk);
        check("t5_no_done", done_cnt_a - d0, 0);
        rx_en_a = 1'b1;
        exp_q_a.push_back(8'h55);
        strobe_a(8'h55, s);
        wait_done(0, 60, dc);
        check("t5_recovery_done", dc - s, 41);

        // Controller-style challenge/response paced on uart_done.
        repeat (4) @(posedge clk);
        controller_run(RESPONSE, ctrl_done);
        check("t6_controller_done", ctrl_done, 1);
        repeat (5) @(negedge clk);
        check("t6_queue_a_drained", exp_q_a.size(), 0);
        check("t6_queue_b_drained", exp_q_b.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit so a stuck DUT still ends the run.
    initial begin : watchdog
        #200000;
        n_fail++;
        $display("FAIL watchdog: time limit reached at cycle %0d, expected test end", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "time limit");
    end

endmodule
